// File: rtl/soc1_cpu_cpu_debug_mon_access.sv
// Debug monitor RAM access engine: turns JTAG command strobes into single-word
// RAM reads/writes and reports MonDReg, monitor_ready and a sticky monitor_error.
module soc1_cpu_cpu_debug_mon_access #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT     = 15,
  parameter logic [31:0] RD_ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [31:0]       ram_wdata,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRdReq, StRdWait, StWr} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              ram_rd_q, ram_rd_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;

  logic              any_strobe;
  logic [ADDR_W-1:0] jdo_addr;
  logic [ADDR_W-1:0] addr_inc;
  logic              unused_jdo;

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign jdo_addr   = jdo[ADDR_W+16:17];
  assign addr_inc   = mon_a_q + ADDR_W'(1);
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mon_a_d     = mon_a_q;
    mon_d_d     = mon_d_q;
    ready_d     = ready_q;
    error_d     = error_q;
    ram_rd_d    = 1'b0;
    ram_wr_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    // Any strobe outside IDLE is a dropped command; the current operation carries on.
    if (state_q != StIdle && any_strobe) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (take_action_ocimem_a) begin
          mon_a_d = jdo_addr;
          error_d = 1'b0;
          if (jdo[35]) begin
            state_d    = StRdReq;
            ready_d    = 1'b0;
            ram_rd_d   = 1'b1;
            ram_addr_d = jdo_addr;
          end
        end else if (take_action_ocimem_b) begin
          mon_d_d     = jdo[34:3];
          error_d     = 1'b0;
          state_d     = StWr;
          ready_d     = 1'b0;
          ram_wr_d    = 1'b1;
          ram_addr_d  = mon_a_q;
          ram_wdata_d = jdo[34:3];
        end else if (take_no_action_ocimem_a) begin
          mon_a_d    = addr_inc;
          error_d    = 1'b0;
          state_d    = StRdReq;
          ready_d    = 1'b0;
          ram_rd_d   = 1'b1;
          ram_addr_d = addr_inc;
        end
      end
      StRdReq: begin
        cnt_d   = CntW'(TIMEOUT);
        state_d = StRdWait;
      end
      StRdWait: begin
        if (ram_rvalid) begin
          mon_d_d = ram_rdata;
          ready_d = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          mon_d_d = RD_ERR_DATA;
          error_d = 1'b1;
          ready_d = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWr: begin
        mon_a_d = addr_inc;
        ready_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mon_a_q     <= '0;
      mon_d_q     <= '0;
      ready_q     <= 1'b1;
      error_q     <= 1'b0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mon_a_q     <= mon_a_d;
      mon_d_q     <= mon_d_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ram_addr      = ram_addr_q;
  assign ram_rd        = ram_rd_q;
  assign ram_wr        = ram_wr_q;
  assign ram_wdata     = ram_wdata_q;
  assign MonAReg       = mon_a_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_soc1_cpu_cpu_debug_mon_access.sv
// Directed bench for the debug monitor access engine with hand-computed expectations.
module tb_soc1_cpu_cpu_debug_mon_access;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [31:0] ram_rdata;
  logic        ram_rvalid;
  logic [7:0]  ram_addr;
  logic        ram_rd;
  logic        ram_wr;
  logic [31:0] ram_wdata;
  logic [7:0]  MonAReg;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int vectors;
  int miscompares;

  soc1_cpu_cpu_debug_mon_access #(
    .ADDR_W     (8),
    .TIMEOUT    (15),
    .RD_ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .ram_rdata              (ram_rdata),
    .ram_rvalid             (ram_rvalid),
    .ram_addr               (ram_addr),
    .ram_rd                 (ram_rd),
    .ram_wr                 (ram_wr),
    .ram_wdata              (ram_wdata),
    .MonAReg                (MonAReg),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1ns after the edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] addr);
    logic [37:0] j;
    j        = '0;
    j[35]    = rd;
    j[24:17] = addr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] j;
    j       = '0;
    j[34:3] = data;
    return j;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(monitor_ready), 32'd1);
    chk({tag, "_error"}, 32'(monitor_error), 32'd0);
    chk({tag, "_mona"}, 32'(MonAReg), 32'd0);
    chk({tag, "_mond"}, MonDReg, 32'd0);
    chk({tag, "_rd"}, 32'(ram_rd), 32'd0);
    chk({tag, "_wr"}, 32'(ram_wr), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_wdata"}, ram_wdata, 32'd0);
  endtask

  initial begin
    vectors                 = 0;
    miscompares             = 0;
    reset_n                 = 1'b0;
    jdo                     = '0;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    ram_rdata               = '0;
    ram_rvalid              = 1'b0;
    #1;
    tick();
    tick();
    check_reset_values("reset");
    reset_n = 1'b1;

    // Read at 0x10, data returned with k=3.
    jdo = jdo_a(1'b1, 8'h10);
    take_action_ocimem_a = 1'b1;
    tick();  // N+1
    take_action_ocimem_a = 1'b0;
    chk("rd_pulse", 32'(ram_rd), 32'd1);
    chk("rd_addr", 32'(ram_addr), 32'h10);
    chk("rd_ready_low", 32'(monitor_ready), 32'd0);
    tick();  // N+2
    chk("rd_single_pulse", 32'(ram_rd), 32'd0);
    tick();  // N+3
    tick();  // N+4
    chk("rd_wait_ready", 32'(monitor_ready), 32'd0);
    ram_rvalid = 1'b1;
    ram_rdata  = 32'h12345678;
    tick();  // N+5
    ram_rvalid = 1'b0;
    chk("rd_data", MonDReg, 32'h12345678);
    chk("rd_ready", 32'(monitor_ready), 32'd1);
    chk("rd_error", 32'(monitor_error), 32'd0);

    // Address-only load to 0xFF, then two writes wrapping to 0x00.
    jdo = jdo_a(1'b0, 8'hFF);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    chk("ld_mona", 32'(MonAReg), 32'hFF);
    chk("ld_ready", 32'(monitor_ready), 32'd1);
    chk("ld_no_rd", 32'(ram_rd), 32'd0);
    jdo = jdo_b(32'hA5A5A5A5);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    chk("wr0_wr", 32'(ram_wr), 32'd1);
    chk("wr0_addr", 32'(ram_addr), 32'hFF);
    chk("wr0_wdata", ram_wdata, 32'hA5A5A5A5);
    chk("wr0_no_rd", 32'(ram_rd), 32'd0);
    chk("wr0_ready", 32'(monitor_ready), 32'd0);
    tick();
    chk("wr0_done_ready", 32'(monitor_ready), 32'd1);
    chk("wr0_done_mona", 32'(MonAReg), 32'h00);
    chk("wr0_done_wr", 32'(ram_wr), 32'd0);
    jdo = jdo_b(32'h5A5A5A5A);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    chk("wr1_wr", 32'(ram_wr), 32'd1);
    chk("wr1_addr", 32'(ram_addr), 32'h00);
    chk("wr1_wdata", ram_wdata, 32'h5A5A5A5A);
    tick();
    chk("wr1_mona", 32'(MonAReg), 32'h01);
    chk("wr1_mond", MonDReg, 32'h5A5A5A5A);
    chk("wr1_ready", 32'(monitor_ready), 32'd1);

    // Read-next from 0x20, k=1.
    jdo = jdo_a(1'b0, 8'h20);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b1;
    tick();  // N+1
    take_no_action_ocimem_a = 1'b0;
    chk("rn_rd", 32'(ram_rd), 32'd1);
    chk("rn_addr", 32'(ram_addr), 32'h21);
    tick();  // N+2
    ram_rvalid = 1'b1;
    ram_rdata  = 32'hCAFE0001;
    tick();  // N+3
    ram_rvalid = 1'b0;
    chk("rn_mond", MonDReg, 32'hCAFE0001);
    chk("rn_mona", 32'(MonAReg), 32'h21);
    chk("rn_ready", 32'(monitor_ready), 32'd1);

    // Timeout: no response, error at N+18.
    jdo = jdo_a(1'b1, 8'h30);
    take_action_ocimem_a = 1'b1;
    tick();  // N+1
    take_action_ocimem_a = 1'b0;
    for (int i = 0; i < 16; i++) tick();  // N+17
    chk("to_not_yet", 32'(monitor_ready), 32'd0);
    tick();  // N+18
    chk("to_ready", 32'(monitor_ready), 32'd1);
    chk("to_error", 32'(monitor_error), 32'd1);
    chk("to_mond", MonDReg, 32'hDEADBEEF);
    ram_rvalid = 1'b1;
    ram_rdata  = 32'h11111111;
    tick();
    ram_rvalid = 1'b0;
    chk("late_rvalid_mond", MonDReg, 32'hDEADBEEF);
    chk("late_rvalid_err", 32'(monitor_error), 32'd1);
    jdo = jdo_a(1'b0, 8'h40);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    chk("err_clear", 32'(monitor_error), 32'd0);
    chk("err_clear_mona", 32'(MonAReg), 32'h40);

    // Strobe while busy: error set, read still completes.
    take_no_action_ocimem_a = 1'b1;
    tick();  // N+1
    take_no_action_ocimem_a = 1'b0;
    tick();  // N+2, RD_WAIT
    jdo = jdo_b(32'h77777777);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    chk("busy_err", 32'(monitor_error), 32'd1);
    chk("busy_ready", 32'(monitor_ready), 32'd0);
    chk("busy_no_wr", 32'(ram_wr), 32'd0);
    ram_rvalid = 1'b1;
    ram_rdata  = 32'h0BADF00D;
    tick();
    ram_rvalid = 1'b0;
    chk("busy_mond", MonDReg, 32'h0BADF00D);
    chk("busy_done_ready", 32'(monitor_ready), 32'd1);
    chk("busy_err_sticky", 32'(monitor_error), 32'd1);
    chk("busy_mona", 32'(MonAReg), 32'h41);

    // a and b together: only the address load happens.
    jdo = jdo_a(1'b0, 8'h50);
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    chk("prio_mona", 32'(MonAReg), 32'h50);
    chk("prio_no_wr", 32'(ram_wr), 32'd0);
    chk("prio_ready", 32'(monitor_ready), 32'd1);
    chk("prio_err", 32'(monitor_error), 32'd0);
    chk("prio_mond", MonDReg, 32'h0BADF00D);
    tick();
    chk("prio_no_wr2", 32'(ram_wr), 32'd0);

    // Reset during RD_WAIT.
    jdo = jdo_a(1'b1, 8'h60);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check_reset_values("midrst");
    reset_n    = 1'b1;
    ram_rvalid = 1'b1;
    ram_rdata  = 32'h99999999;
    tick();
    ram_rvalid = 1'b0;
    chk("post_rst_mond", MonDReg, 32'd0);
    chk("post_rst_ready", 32'(monitor_ready), 32'd1);
    chk("post_rst_rd", 32'(ram_rd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/soc1_cpu_cpu_debug_mon_access.md
# soc1_cpu_cpu_debug_mon_access

Monitor memory-access engine for the CPU debug path. Consumes the system-clock-domain JTAG command strobes and the 38-bit `jdo` data word produced by the debug slave, and performs single-word reads and writes to the debug monitor RAM. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug slave for scan-out. Sits between the debug slave system-clock stage and the monitor RAM, clocked on `clk`.

## Interface
- `ADDR_W`, 8: monitor RAM word-address width; the address wraps modulo 2^ADDR_W; legal range 1..15.
- `TIMEOUT`, 15: maximum wait in cycles for `ram_rvalid` after `ram_rd`; must be ≥1. The counter is ceil(log2(TIMEOUT+1)) bits.
- `RD_ERR_DATA`, 32'hDEADBEEF: value loaded into `MonDReg` on a read timeout.

Ports:
- `clk` in 1: sole clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `jdo` in 38: JTAG data word; valid in the cycle a strobe is high.
- `take_action_ocimem_a` in 1: load-address command, one-cycle strobe.
- `take_action_ocimem_b` in 1: write command, one-cycle strobe.
- `take_no_action_ocimem_a` in 1: read-next command, one-cycle strobe.
- `ram_rdata` in 32: RAM read data.
- `ram_rvalid` in 1: `ram_rdata` is valid this cycle.
- `ram_addr` out ADDR_W: RAM word address.
- `ram_rd` out 1: read request, one-cycle pulse.
- `ram_wr` out 1: write strobe, one-cycle pulse; the RAM always accepts it.
- `ram_wdata` out 32: write data.
- `MonAReg` out ADDR_W: current monitor address.
- `MonDReg` out 32: last read data, or last write data.
- `monitor_ready` out 1: engine idle and last result valid.
- `monitor_error` out 1: sticky error flag.

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR.
- Strobes are sampled only in IDLE. Priority is `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. Lower-priority strobes in the same cycle are discarded without error.
- `take_action_ocimem_a`:
  - `MonAReg` ← `jdo[ADDR_W+16:17]`.
  - If `jdo[35]`=1, go to RD_REQ. Otherwise stay IDLE; `monitor_ready` stays 1.
- `take_action_ocimem_b`: `MonDReg` ← `jdo[34:3]`, then go to WR.
- `take_no_action_ocimem_a`: `MonAReg` ← `MonAReg`+1 (wraps from 2^ADDR_W−1 to 0), then go to RD_REQ.
- Every accepted command clears `monitor_error`. Every command that leaves IDLE drops `monitor_ready`.
- RD_REQ:
  - `ram_rd`=1 and `ram_addr`=`MonAReg` for exactly one cycle.
  - Load the timeout counter with TIMEOUT, then go to RD_WAIT.
- RD_WAIT, with `ram_rvalid`=1: `MonDReg` ← `ram_rdata`, `monitor_ready` ← 1, go to IDLE.
- RD_WAIT, counter at 0 and no `ram_rvalid`: `MonDReg` ← RD_ERR_DATA, `monitor_error` ← 1, `monitor_ready` ← 1, go to IDLE.
- RD_WAIT, otherwise: decrement the counter.
- If `ram_rvalid` and expiry coincide, `ram_rvalid` wins and there is no error.
- WR:
  - `ram_wr`=1, `ram_addr`=`MonAReg`, `ram_wdata`=`MonDReg` for one cycle.
  - Next cycle: `MonAReg` ← `MonAReg`+1 (wrapping), `monitor_ready` ← 1, go to IDLE.
- Strobe while not IDLE: the command is dropped, `monitor_error` ← 1, and the operation in progress is unaffected.
- `ram_rvalid` outside RD_WAIT is ignored. This covers stale responses arriving after a timeout or a reset.
- `ram_rd` and `ram_wr` are never high in the same cycle.

## Timing
- All outputs are registered.
- Reset values, applied on the first rising edge with `reset_n`=0:
  - state IDLE;
  - `MonAReg`=0, `MonDReg`=0;
  - `monitor_ready`=1, `monitor_error`=0;
  - `ram_rd`=0, `ram_wr`=0, `ram_addr`=0, `ram_wdata`=0.
- Reset mid-operation aborts it immediately; there is no RAM access after reset.
- Read:
  - strobe in cycle N → `monitor_ready`=0 and `ram_rd`=1 in cycle N+1;
  - `ram_rvalid` in cycle N+1+k, k≥1 → `MonDReg` updated and `monitor_ready`=1 in cycle N+2+k.
- Read timeout: `monitor_ready`=1 and `monitor_error`=1 in cycle N+3+TIMEOUT.
- Write:
  - strobe in cycle N → `ram_wr`=1 in cycle N+1;
  - `MonAReg` incremented and `monitor_ready`=1 in cycle N+2.
- Address-only load: `MonAReg` updated in cycle N+1; `monitor_ready` never drops.
- Back-to-back commands: the next strobe is accepted in the first cycle in which `monitor_ready`=1.

## Test plan
- Reset, then read: set `reset_n`=0 for 2 cycles. Apply `take_action_ocimem_a` with `jdo[35]`=1 and `jdo[24:17]`=8'h10. RAM returns 32'h12345678 with k=3.
  - `ram_rd` is a single pulse at `ram_addr`=8'h10.
  - `MonDReg`=32'h12345678 and `monitor_ready`=1 in cycle N+5; `monitor_error`=0.
- Write burst with wrap: load address 8'hFF with `jdo[35]`=0. Then apply `take_action_ocimem_b` twice with `jdo[34:3]`=32'hA5A5A5A5 and 32'h5A5A5A5A.
  - Writes go to 8'hFF then 8'h00.
  - `MonAReg` ends at 8'h01.
- Read-next: with `MonAReg`=8'h20, apply `take_no_action_ocimem_a`.
  - `ram_rd` is issued at 8'h21.
  - `MonAReg`=8'h21 after completion.
- Timeout: issue a read and never assert `ram_rvalid`.
  - `MonDReg`=32'hDEADBEEF and `monitor_error`=1 at cycle N+18.
  - A late `ram_rvalid` in IDLE leaves `MonDReg` unchanged.
  - The next accepted command clears `monitor_error`.
- Busy collision and priority:
  - A strobe during RD_WAIT sets `monitor_error` and the read still completes.
  - `take_action_ocimem_a` and `take_action_ocimem_b` asserted together: only the address load happens and `ram_wr` never pulses.
- Reset mid-read: assert `reset_n`=0 in RD_WAIT.
  - All outputs return to reset values on the next edge.
  - A subsequent `ram_rvalid` is ignored.
